// File: rtl/led_seq_pkg.sv
// Shared types for the LED sequencer: pattern modes and bounce direction.
package led_seq_pkg;

    typedef enum logic [1:0] {
        COUNT  = 2'd0,
        SHIFT  = 2'd1,
        BOUNCE = 2'd2,
        HOLD   = 2'd3
    } led_mode_e;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } bounce_dir_e;

endpackage

// File: rtl/led_seq_divider.sv
// Step-rate divider: counts 0..DIV-1 while enabled and emits a registered
// one-cycle tick in the cycle after the count reaches DIV-1.
module led_seq_divider #(
    parameter int DIV = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    if (DIV < 2) begin : g_div_check
        $error("led_seq_divider: DIV must be at least 2");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Disabling clears the count so a re-enable always waits a full period.
    always_comb begin
        cnt_d  = '0;
        tick_d = 1'b0;
        if (en) begin
            tick_d = (cnt_q == LAST);
            cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: COUNT / SHIFT / BOUNCE / HOLD patterns stepped by a divider tick.
// Optional PWM brightness gating is compiled in with `define LED_SEQ_PWM_EN.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int DIV      = 1_000_000,
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] brightness,
    output logic                tick,
    output logic [NUM_LEDS-1:0] leds
);

    localparam logic [NUM_LEDS-1:0] ONE = {{(NUM_LEDS-1){1'b0}}, 1'b1};

    if (NUM_LEDS < 2) begin : g_leds_check
        $error("led_sequencer: NUM_LEDS must be at least 2");
    end

    logic                tick_w;
    logic [NUM_LEDS-1:0] pattern_q, pattern_d;
    logic [NUM_LEDS-1:0] leds_q, leds_d;
    led_mode_e           mode_q, mode_d, mode_in;
    bounce_dir_e         dir_q, dir_d;

    led_seq_divider #(.DIV(DIV)) u_divider (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick_w)
    );

    assign mode_in = led_mode_e'(mode);

    // A mode change spends its step loading the new seed rather than advancing.
    always_comb begin
        pattern_d = pattern_q;
        mode_d    = mode_q;
        dir_d     = dir_q;
        if (tick_w) begin
            mode_d = mode_in;
            if (mode_in != mode_q) begin
                case (mode_in)
                    COUNT:  pattern_d = '0;
                    SHIFT:  pattern_d = ONE;
                    BOUNCE: begin
                        pattern_d = ONE;
                        dir_d     = UP;
                    end
                    default: pattern_d = pattern_q;
                endcase
            end else begin
                case (mode_q)
                    COUNT:  pattern_d = pattern_q + ONE;
                    SHIFT:  pattern_d = {pattern_q[NUM_LEDS-2:0], pattern_q[NUM_LEDS-1]};
                    BOUNCE: begin
                        if (dir_q == UP) begin
                            pattern_d = pattern_q << 1;
                            if (pattern_d[NUM_LEDS-1]) dir_d = DOWN;
                        end else begin
                            pattern_d = pattern_q >> 1;
                            if (pattern_d[0]) dir_d = UP;
                        end
                    end
                    default: pattern_d = pattern_q;
                endcase
            end
        end
    end

`ifdef LED_SEQ_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                pwm_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt_q <= '0;
        else        pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
    end

    // Full-scale brightness is treated as always-on so it reaches 100% duty.
    assign pwm_on = (pwm_cnt_q < brightness) || (&brightness);
    assign leds_d = pattern_q & {NUM_LEDS{pwm_on}};
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign leds_d            = pattern_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q <= '0;
            mode_q    <= COUNT;
            dir_q     <= UP;
            leds_q    <= '0;
        end else begin
            pattern_q <= pattern_d;
            mode_q    <= mode_d;
            dir_q     <= dir_d;
            leds_q    <= leds_d;
        end
    end

    assign tick = tick_w;
    assign leds = leds_q;

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 NUM_LEDS, default 8: LED channel count; SHALL be at least 2 (elaboration error otherwise).
REQ-002 DIV, default 1_000_000: clock cycles per pattern step; SHALL be at least 2 (elaboration error otherwise).
REQ-003 PWM_BITS, default 4: brightness resolution in bits.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  run enable; 0 freezes the pattern and clears the divider.
REQ-008 mode  input  2  pattern select: 0 COUNT, 1 SHIFT, 2 BOUNCE, 3 HOLD.
REQ-009 brightness  input  PWM_BITS  global duty level; used only with the PWM feature.
REQ-010 tick  output  1  registered one-cycle step strobe.
REQ-011 leds  output  NUM_LEDS  registered LED drive.

Function
REQ-012 Divider: counts 0..DIV-1 while en=1 and wraps to 0; when en=0 it is held at 0.
REQ-013 tick SHALL be high for exactly one cycle, in the cycle after the divider reaches DIV-1 with en=1, giving one tick every DIV cycles.
REQ-014 The pattern register SHALL update only on the edge that ends a tick cycle; the new pattern is visible on leds one cycle later.
REQ-015 mode SHALL be sampled only in tick cycles; the sampled value is held in an active-mode register.
REQ-016 When the sampled mode differs from the active mode, the step SHALL load the new mode's seed instead of advancing: COUNT 0, SHIFT 1, BOUNCE 1 with direction UP, HOLD keeps the current pattern.
REQ-017 COUNT: pattern increments by 1 modulo 2^NUM_LEDS; all-ones wraps to 0.
REQ-018 SHIFT: rotate left by one; bit NUM_LEDS-1 wraps to bit 0.
REQ-019 BOUNCE: two-state FSM, UP and DOWN.
REQ-020 BOUNCE UP: shift left; if the result has bit NUM_LEDS-1 set, go to DOWN.
REQ-021 BOUNCE DOWN: shift right; if the result has bit 0 set, go to UP.
REQ-022 BOUNCE sequence, with no repeat at the ends, SHALL be 0001,0010,0100,1000,0100,0010,0001,0010 for NUM_LEDS=4.
REQ-023 HOLD: pattern and FSM state are unchanged on tick.
REQ-024 en deasserted mid-period: no tick is issued and the pattern is held; on re-enable, the next tick follows after a full DIV cycles.
REQ-025 If mode changes while en=0, the change SHALL take effect at the first tick after re-enable.

Reset
REQ-026 On rst_n low, regardless of clk: divider 0, tick 0, active mode COUNT, pattern 0, FSM state UP, leds 0, PWM counter 0.
REQ-027 Reset asserted mid-step SHALL discard any pending mode change.
REQ-028 After rst_n rises, the first tick occurs DIV cycles after the first enabled cycle.

Configuration
REQ-029 Macro LED_SEQ_PWM_EN SHALL compile the PWM feature in or out.
REQ-030 With LED_SEQ_PWM_EN defined: a free-running PWM_BITS counter runs while out of reset. leds = pattern AND pwm_on, where pwm_on = (pwm_cnt < brightness) OR (brightness = all-ones). brightness 0 gives leds all 0.
REQ-031 Without LED_SEQ_PWM_EN: there is no PWM counter, the brightness input is ignored, and leds = pattern registered.

Structure
REQ-032 Package led_seq_pkg SHALL hold the mode enum (COUNT, SHIFT, BOUNCE, HOLD) and the bounce direction enum (UP, DOWN).
REQ-033 Divider and tick generation SHALL live in a sub-module, led_seq_divider, with parameter DIV and ports clk, rst_n, en, tick.
REQ-034 The pattern FSM, mode register and PWM logic SHALL live in led_sequencer.

Verification
REQ-035 Tick timing: DIV=4, en=1 -> tick pulses every 4 cycles, each 1 cycle wide; en=0 for 2 cycles mid-period -> the next tick comes 4 cycles after re-enable.
REQ-036 COUNT wrap: NUM_LEDS=4, DIV=2, mode=0 -> leds 0,1,...,15,0 on successive ticks.
REQ-037 SHIFT then BOUNCE: NUM_LEDS=4; SHIFT gives 0001,0010,0100,1000,0001. Switch to mode=2 -> the next tick loads 0001, then the bounce sequence per REQ-022.
REQ-038 HOLD plus reset: in BOUNCE at 0100 direction DOWN, mode=3 -> 0100 holds over 5 ticks. rst_n pulsed low between clock edges -> leds 0 immediately, mode COUNT.
REQ-039 PWM with LED_SEQ_PWM_EN defined: PWM_BITS=4, pattern 1111. brightness=4 -> leds high 4 of every 16 cycles; brightness=0 -> always 0; brightness=15 -> always 1111.
REQ-040 PWM without LED_SEQ_PWM_EN: any brightness value -> leds equal the pattern.
